// File: rtl/bp_cache_assoc.sv
// rtl/bp_cache_assoc.sv - set-associative branch-predictor cache, 2 read ports, 1 write port, flush sweep (option: BP_CACHE_ASSOC_FWD_EN)
module bp_cache_assoc #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 2,
  parameter int LINES  = 8,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] ra0,
  output logic [DWIDTH-1:0] dout0,
  output logic              hit0,
  input  logic [AWIDTH-1:0] ra1,
  output logic [DWIDTH-1:0] dout1,
  output logic              hit1,
  input  logic [AWIDTH-1:0] wa,
  input  logic [DWIDTH-1:0] din,
  input  logic              we,
  input  logic              flush,
  output logic              busy
);

  localparam int IDX = $clog2(LINES);
  localparam int TW  = AWIDTH - 2 - IDX;
  localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t            r_state, w_next_state;
  logic [IDX-1:0]    r_cnt, w_next_cnt;

  logic [WAYS-1:0]   r_valid [LINES];
  logic [TW-1:0]     r_tag   [LINES][WAYS];
  logic [DWIDTH-1:0] r_data  [LINES][WAYS];
  logic [WW-1:0]     r_rr    [LINES];

  logic [IDX-1:0]    w_wa_idx;
  logic [TW-1:0]     w_wa_tag;
  logic              w_wr_en;
  logic              w_hit_any, w_inv_any;
  logic [WW-1:0]     w_hit_way, w_inv_way, w_victim;
  logic              w_unused;

  assign w_unused = ^{ra0[1:0], ra1[1:0], wa[1:0]};

  assign busy     = (r_state == S_SWEEP);
  assign w_wa_idx = wa[2 +: IDX];
  assign w_wa_tag = wa[AWIDTH-1:2+IDX];
  // Flush takes precedence over a same-cycle write; the sweep drops all writes.
  assign w_wr_en  = we & ~busy & ~flush;

  // Associative lookup for one read port: {hit, data}, forced to a miss while sweeping.
  function automatic logic [DWIDTH:0] f_lookup(input logic [AWIDTH-1:0] a);
    logic [IDX-1:0]    idx;
    logic [TW-1:0]     tag;
    logic              hit;
    logic [DWIDTH-1:0] data;
    idx  = a[2 +: IDX];
    tag  = a[AWIDTH-1:2+IDX];
    hit  = 1'b0;
    data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[idx][w] && (r_tag[idx][w] == tag)) begin
        hit  = 1'b1;
        data = r_data[idx][w];
      end
    end
`ifdef BP_CACHE_ASSOC_FWD_EN
    if (w_wr_en && (idx == w_wa_idx) && (tag == w_wa_tag)) begin
      hit  = 1'b1;
      data = din;
    end
`endif
    if (busy) begin
      hit  = 1'b0;
      data = '0;
    end
    return {hit, data};
  endfunction

  // Read ports: purely combinational, identical logic for fetch and execute.
  always_comb begin
    {hit0, dout0} = f_lookup(ra0);
    {hit1, dout1} = f_lookup(ra1);
  end

  // Write-side way selection: tag hit first, else lowest invalid way, else round-robin.
  always_comb begin
    w_hit_any = 1'b0;
    w_hit_way = '0;
    w_inv_any = 1'b0;
    w_inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_wa_idx][w] && (r_tag[w_wa_idx][w] == w_wa_tag)) begin
        w_hit_any = 1'b1;
        w_hit_way = WW'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_wa_idx][w]) begin
        w_inv_any = 1'b1;
        w_inv_way = WW'(w);
      end
    end
    if (w_hit_any)      w_victim = w_hit_way;
    else if (w_inv_any) w_victim = w_inv_way;
    else                w_victim = r_rr[w_wa_idx];
  end

  // FSM state and sweep counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // FSM next state: one set cleared per sweep cycle, LINES cycles in total.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (flush) begin
          w_next_state = S_SWEEP;
          w_next_cnt   = '0;
        end
      end
      S_SWEEP: begin
        w_next_cnt = r_cnt + 1'b1;
        if (r_cnt == IDX'(LINES - 1)) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Valid bits and round-robin pointers: cleared by reset or the sweep, set on allocation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) begin
        r_valid[i] <= '0;
        r_rr[i]    <= '0;
      end
    end else if (r_state == S_SWEEP) begin
      r_valid[r_cnt] <= '0;
      r_rr[r_cnt]    <= '0;
    end else if (w_wr_en && !w_hit_any) begin
      r_valid[w_wa_idx][w_victim] <= 1'b1;
      if (!w_inv_any) r_rr[w_wa_idx] <= (WAYS == 1) ? '0 : r_rr[w_wa_idx] + 1'b1;
    end
  end

  // Tag/data arrays carry no reset; a write hit only refreshes the payload.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_data[w_wa_idx][w_victim] <= din;
      if (!w_hit_any) r_tag[w_wa_idx][w_victim] <= w_wa_tag;
    end
  end

endmodule

// File: tb/tb_bp_cache_assoc.sv
// tb/tb_bp_cache_assoc.sv - self-checking bench for bp_cache_assoc (LINES=8, WAYS=2)
module tb_bp_cache_assoc;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ra0, ra1, wa;
  logic [1:0]  dout0, dout1, din;
  logic        hit0, hit1, we, flush, busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    logic       hit;
    logic [1:0] dout;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [1:0]  data;
    logic        exp_hit;
    logic [1:0]  exp_dout;
  } vec_t;
  vec_t vecs[$];

  bp_cache_assoc #(.AWIDTH(32), .DWIDTH(2), .LINES(8), .WAYS(2)) dut (
    .clk(clk), .reset(reset),
    .ra0(ra0), .dout0(dout0), .hit0(hit0),
    .ra1(ra1), .dout1(dout1), .hit1(hit1),
    .wa(wa), .din(din), .we(we), .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit w, input logic [31:0] a, input logic [1:0] d,
                              input logic h, input logic [1:0] o);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.exp_hit = h; v.exp_dout = o;
    return v;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [1:0] d);
    @(negedge clk);
    we = 1'b1; wa = a; din = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic h, input logic [1:0] o);
    exp_t e;
    @(negedge clk);
    ra0 = a; ra1 = a;
    sb.push_back('{$sformatf("rd0_%0h", a), h, o});
    sb.push_back('{$sformatf("rd1_%0h", a), h, o});
    #1;
    e = sb.pop_front();
    check({e.name, "_hit"}, 32'(hit0), 32'(e.hit));
    check({e.name, "_dout"}, 32'(dout0), 32'(e.dout));
    e = sb.pop_front();
    check({e.name, "_hit"}, 32'(hit1), 32'(e.hit));
    check({e.name, "_dout"}, 32'(dout1), 32'(e.dout));
  endtask

  initial begin
    int busy_cnt;
    reset = 1'b1; ra0 = '0; ra1 = '0; wa = '0; din = '0; we = 1'b0; flush = 1'b0;

    vecs.push_back(mk(0, 32'h00, 2'b00, 0, 2'b00));
    vecs.push_back(mk(1, 32'h00, 2'b11, 0, 2'b00));
    vecs.push_back(mk(0, 32'h00, 2'b00, 1, 2'b11));
    vecs.push_back(mk(0, 32'h20, 2'b00, 0, 2'b00));
    vecs.push_back(mk(1, 32'h00, 2'b01, 0, 2'b00));
    vecs.push_back(mk(1, 32'h20, 2'b10, 0, 2'b00));
    vecs.push_back(mk(1, 32'h40, 2'b11, 0, 2'b00));
    vecs.push_back(mk(0, 32'h00, 2'b00, 0, 2'b00));
    vecs.push_back(mk(0, 32'h20, 2'b00, 1, 2'b10));
    vecs.push_back(mk(0, 32'h40, 2'b00, 1, 2'b11));
    vecs.push_back(mk(1, 32'h20, 2'b00, 0, 2'b00));
    vecs.push_back(mk(0, 32'h20, 2'b00, 1, 2'b00));
    vecs.push_back(mk(1, 32'h60, 2'b01, 0, 2'b00));
    vecs.push_back(mk(0, 32'h20, 2'b00, 0, 2'b00));
    vecs.push_back(mk(0, 32'h40, 2'b00, 1, 2'b11));
    vecs.push_back(mk(0, 32'h60, 2'b00, 1, 2'b01));
    vecs.push_back(mk(1, 32'h80, 2'b10, 0, 2'b00));
    vecs.push_back(mk(0, 32'h40, 2'b00, 0, 2'b00));
    vecs.push_back(mk(0, 32'h80, 2'b00, 1, 2'b10));
    vecs.push_back(mk(0, 32'h60, 2'b00, 1, 2'b01));
    vecs.push_back(mk(1, 32'h04, 2'b10, 0, 2'b00));
    vecs.push_back(mk(1, 32'h1C, 2'b01, 0, 2'b00));
    vecs.push_back(mk(0, 32'h04, 2'b00, 1, 2'b10));
    vecs.push_back(mk(0, 32'h1C, 2'b00, 1, 2'b01));
    vecs.push_back(mk(0, 32'h07, 2'b00, 1, 2'b10));
    vecs.push_back(mk(0, 32'h24, 2'b00, 0, 2'b00));
    vecs.push_back(mk(0, 32'h84, 2'b00, 0, 2'b00));

    #12;
    check("busy_in_reset", 32'(busy), 32'd0);
    check("hit0_in_reset", 32'(hit0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("busy_after_reset", 32'(busy), 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data);
      else               do_read(vecs[i].addr, vecs[i].exp_hit, vecs[i].exp_dout);
    end

    // Flush with a same-cycle write, then writes and a flush pulse during the sweep.
    @(negedge clk);
    flush = 1'b1; we = 1'b1; wa = 32'hA0; din = 2'b11; ra0 = 32'h04; ra1 = 32'h1C;
    @(negedge clk);
    flush = 1'b0; wa = 32'h08; din = 2'b01;
    busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (!busy) break;
      busy_cnt++;
      check("sweep_hit0", 32'(hit0), 32'd0);
      check("sweep_hit1", 32'(hit1), 32'd0);
      flush = (c == 3);
      @(negedge clk);
    end
    we = 1'b0; flush = 1'b0;
    check("sweep_busy_cycles", 32'(busy_cnt), 32'd8);
    do_read(32'hA0, 0, 2'b00);
    do_read(32'h08, 0, 2'b00);
    do_read(32'h80, 0, 2'b00);
    do_read(32'h60, 0, 2'b00);
    do_read(32'h04, 0, 2'b00);
    do_read(32'h1C, 0, 2'b00);
    do_write(32'h10, 2'b01);
    do_read(32'h10, 1, 2'b01);

    // Reset in the third sweep cycle.
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_mid_sweep", 32'(busy), 32'd1);
    reset = 1'b1;
    ra0 = 32'h10;
    #1;
    check("busy_on_reset", 32'(busy), 32'd0);
    check("hit0_on_reset", 32'(hit0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("busy_after_mid_reset", 32'(busy), 32'd0);
    do_read(32'h10, 0, 2'b00);

    // Same-cycle visibility of a write to a different set on the other port.
    @(negedge clk);
    we = 1'b1; wa = 32'h44; din = 2'b10; ra0 = 32'h44; ra1 = 32'h40;
    #1;
`ifdef BP_CACHE_ASSOC_FWD_EN
    check("fwd_hit0", 32'(hit0), 32'd1);
    check("fwd_dout0", 32'(dout0), 32'd2);
`else
    check("nofwd_hit0", 32'(hit0), 32'd0);
    check("nofwd_dout0", 32'(dout0), 32'd0);
`endif
    check("fwd_other_set_hit1", 32'(hit1), 32'd0);
    @(posedge clk);
    #1;
    we = 1'b0;
    do_read(32'h44, 1, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
